// File: rtl/asip_loader_pkg.sv
// Shared definitions for the ASIP program/data loader: default widths,
// header field positions, opcode and FSM state encodings, decoded header.
package asip_loader_pkg;

    localparam int MEM_W_DEF     = 32;
    localparam int IMEMADDRW_DEF = 7;
    localparam int DMEMADDRW_DEF = 10;

    // Header word layout
    localparam int HDR_OP_HI   = 31;
    localparam int HDR_OP_LO   = 30;
    localparam int HDR_CNT_HI  = 29;
    localparam int HDR_CNT_LO  = 20;
    localparam int HDR_BASE_HI = 9;
    localparam int HDR_BASE_LO = 0;
    localparam int HDR_CNT_W   = HDR_CNT_HI - HDR_CNT_LO + 1;
    localparam int HDR_BASE_W  = HDR_BASE_HI - HDR_BASE_LO + 1;

    typedef enum logic [1:0] {
        OP_LD_IMEM = 2'b00,
        OP_LD_DMEM = 2'b01,
        OP_RUN     = 2'b10,
        OP_STOP    = 2'b11
    } op_e;

    // CHK only exists when the checksum feature is built in
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK  = 2'd2,
`endif
        ST_RUN  = 2'd3
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [HDR_CNT_W-1:0]  cnt_m1;
        logic [HDR_BASE_W-1:0] base;
    } hdr_t;

endpackage

// File: rtl/asip_loader_if.sv
// Host word stream into the loader: valid/ready handshake plus data word.
interface asip_loader_if
    import asip_loader_pkg::*;
#(
    parameter int MEM_W = MEM_W_DEF
);
    logic             h_valid;
    logic             h_ready;
    logic [MEM_W-1:0] h_data;

    modport master (output h_valid, output h_data, input h_ready);
    modport slave  (input h_valid, input h_data, output h_ready);
endinterface

// File: rtl/asip_loader_hdr_dec.sv
// Combinational header decode: splits a host word into opcode, count-1, base.
module loader_hdr_dec
    import asip_loader_pkg::*;
(
    input  logic [31:0] word,
    output hdr_t        hdr
);
    // Bits between the count and base fields carry no meaning
    logic unused_gap;
    assign unused_gap = ^word[HDR_CNT_LO-1:HDR_BASE_HI+1];

    assign hdr.op     = op_e'(word[HDR_OP_HI:HDR_OP_LO]);
    assign hdr.cnt_m1 = word[HDR_CNT_HI:HDR_CNT_LO];
    assign hdr.base   = word[HDR_BASE_HI:HDR_BASE_LO];
endmodule

// File: rtl/asip_loader.sv
// ASIP loader: takes a header/payload word stream from the host, writes the
// payload into instruction or data memory, and hands the memories to the
// core on a run header until a stop header arrives.
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of payload words,
// checked against one extra word after each load; mismatch sets sticky err).
module asip_loader
    import asip_loader_pkg::*;
#(
    parameter int MEM_W     = MEM_W_DEF,   // must be >= 32 (header is 32 bits)
    parameter int IMEMADDRW = IMEMADDRW_DEF,
    parameter int DMEMADDRW = DMEMADDRW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_b,
    asip_loader_if.slave         host,
    output logic                 imem_we,
    output logic [IMEMADDRW-1:0] imem_addr,
    output logic                 dmem_we,
    output logic [DMEMADDRW-1:0] dmem_addr,
    output logic [MEM_W-1:0]     mem_din,
    output logic                 t_cs,
    output logic                 busy,
    output logic                 err
);
    // One address counter wide enough for either memory; each port takes
    // its low bits, which gives the modulo wrap for free.
    localparam int AW = (IMEMADDRW > DMEMADDRW) ? IMEMADDRW : DMEMADDRW;

    state_e               state;
    hdr_t                 hdr;
    logic                 ready_q;
    logic                 xfer;
    logic                 tgt_dmem;
    logic [AW-1:0]        addr_cnt;
    logic [HDR_CNT_W-1:0] rem;      // payload words left after the current one
    logic                 run_ok;

`ifdef LOADER_CHECKSUM_EN
    logic [MEM_W-1:0] csum;
    logic             err_q;
    assign err    = err_q;
    assign run_ok = ~err_q;
`else
    assign err    = 1'b0;
    assign run_ok = 1'b1;
`endif

    assign host.h_ready = ready_q;
    assign xfer         = host.h_valid & ready_q;

    loader_hdr_dec u_hdr_dec (
        .word (host.h_data[31:0]),
        .hdr  (hdr)
    );

    // Loader FSM: header handling, payload write sequencing, run/stop handover
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b0;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            imem_addr <= '0;
            dmem_addr <= '0;
            mem_din   <= '0;
            t_cs      <= 1'b0;
            busy      <= 1'b0;
            tgt_dmem  <= 1'b0;
            addr_cnt  <= '0;
            rem       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            // Ready in every state once out of reset; strobes are single-cycle
            ready_q <= 1'b1;
            imem_we <= 1'b0;
            dmem_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (hdr.op == OP_LD_IMEM || hdr.op == OP_LD_DMEM) begin
                            tgt_dmem <= (hdr.op == OP_LD_DMEM);
                            addr_cnt <= AW'(hdr.base);
                            rem      <= hdr.cnt_m1;
`ifdef LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                            busy     <= 1'b1;
                            state    <= ST_LOAD;
                        end else if (hdr.op == OP_RUN && run_ok) begin
                            t_cs  <= 1'b1;
                            state <= ST_RUN;
                        end
                        // stop header (or refused run) is dropped
                    end
                end

                ST_LOAD: begin
                    if (xfer) begin
                        mem_din <= host.h_data;
                        if (tgt_dmem) begin
                            dmem_we   <= 1'b1;
                            dmem_addr <= addr_cnt[DMEMADDRW-1:0];
                        end else begin
                            imem_we   <= 1'b1;
                            imem_addr <= addr_cnt[IMEMADDRW-1:0];
                        end
                        addr_cnt <= addr_cnt + AW'(1);
                        rem      <= rem - HDR_CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ host.h_data;
                        if (rem == '0) begin
                            state <= ST_CHK;
                        end
`else
                        if (rem == '0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) begin
                        if (host.h_data != csum) begin
                            err_q <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
`endif

                ST_RUN: begin
                    // Core owns the memories; only a stop header matters
                    if (xfer && hdr.op == OP_STOP) begin
                        t_cs  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    t_cs  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asip_loader.sv
// Self-checking bench for asip_loader: directed scenarios with literal
// expectations plus randomized command streams against a transaction-level
// model of the loader. Honours LOADER_CHECKSUM_EN when defined.
module tb_asip_loader;
    localparam int MEM_W = 32;
    localparam int IAW   = 7;
    localparam int DAW   = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_LOAD = 1, M_CHK = 2, M_RUN = 3;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             imem_we, dmem_we, t_cs, busy, err;
    logic [IAW-1:0]   imem_addr;
    logic [DAW-1:0]   dmem_addr;
    logic [MEM_W-1:0] mem_din;

    asip_loader_if #(.MEM_W(MEM_W)) bus();

    asip_loader #(.MEM_W(MEM_W), .IMEMADDRW(IAW), .DMEMADDRW(DAW)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .host      (bus),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .mem_din   (mem_din),
        .t_cs      (t_cs),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_mode, m_base, m_cnt, m_idx;
    bit          m_dmem;
    logic [31:0] m_csum;
    bit          e_ready, e_imem_we, e_dmem_we, e_err;
    int          e_iaddr, e_daddr;
    logic [31:0] e_din;

    task automatic mdl_reset();
        m_mode = M_IDLE; m_base = 0; m_cnt = 0; m_idx = 0; m_dmem = 0; m_csum = 0;
        e_ready = 0; e_imem_we = 0; e_dmem_we = 0; e_err = 0;
        e_iaddr = 0; e_daddr = 0; e_din = 0;
    endtask

    task automatic mdl_word(input logic [31:0] w);
        int op, a;
        op = int'(w >> 30);
        case (m_mode)
            M_IDLE: begin
                if (op <= 1) begin
                    m_dmem = (op == 1);
                    m_base = int'(w & 32'h3FF);
                    m_cnt  = int'((w >> 20) & 32'h3FF) + 1;
                    m_idx  = 0;
                    m_csum = 0;
                    m_mode = M_LOAD;
                end else if (op == 2 && !e_err) m_mode = M_RUN;
            end
            M_LOAD: begin
                a = m_base + m_idx;
                if (m_dmem) begin e_dmem_we = 1; e_daddr = a % (1 << DAW); end
                else begin e_imem_we = 1; e_iaddr = a % (1 << IAW); end
                e_din = w;
                m_csum = m_csum ^ w;
                m_idx++;
                if (m_idx == m_cnt) m_mode = CK_EN ? M_CHK : M_IDLE;
            end
            M_CHK: begin
                if (w !== m_csum) e_err = 1;
                m_mode = M_IDLE;
            end
            M_RUN: if (op == 3) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endtask

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) mdl_reset();
        else begin
            cyc++;
            e_imem_we = 0;
            e_dmem_we = 0;
            if (bus.h_valid && e_ready) mdl_word(bus.h_data);
            e_ready = 1;
        end
    end

    // ---------------- write log + per-cycle compare ----------------
    typedef struct { bit d; int addr; logic [31:0] data; int cyc; } wr_t;
    wr_t log_q[$];

    always @(negedge clk) begin
        check("h_ready", 32'(bus.h_ready), 32'(e_ready));
        check("imem_we", 32'(imem_we), 32'(e_imem_we));
        check("dmem_we", 32'(dmem_we), 32'(e_dmem_we));
        check("t_cs", 32'(t_cs), 32'(m_mode == M_RUN));
        check("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_CHK));
        check("err", 32'(err), 32'(e_err));
        check("mem_din", mem_din, e_din);
        if (e_imem_we) check("imem_addr", 32'(imem_addr), 32'(e_iaddr));
        if (e_dmem_we) check("dmem_addr", 32'(dmem_addr), 32'(e_daddr));
        if (imem_we) log_q.push_back('{1'b0, int'(imem_addr), mem_din, cyc});
        if (dmem_we) log_q.push_back('{1'b1, int'(dmem_addr), mem_din, cyc});
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] payv[16];

    task automatic put(input logic [31:0] w);
        @(negedge clk);
        bus.h_valid = 1'b1;
        bus.h_data  = w;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.h_valid = 1'b0;
            bus.h_data  = $urandom;
        end
    endtask

    task automatic load(input bit d, input int base, input int n, input int gap_at,
                        input int gap_len, input bit bad_ck);
        logic [31:0] ck;
        ck = 0;
        put({1'b0, d, 10'(n - 1), 10'd0, 10'(base)});
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) idle(gap_len);
            put(payv[i]);
            ck = ck ^ payv[i];
        end
        if (bad_ck) ck = ~ck;
`ifdef LOADER_CHECKSUM_EN
        put(ck);
`endif
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        bus.h_valid = 1'b0;
        idle(2);
        reset_b = 1'b1;
        idle(2);
    endtask

    initial begin
        bus.h_valid = 1'b0;
        bus.h_data  = '0;
        // reset state
        @(negedge clk);
        check("rst_h_ready", 32'(bus.h_ready), 0);
        check("rst_t_cs", 32'(t_cs), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_din", mem_din, 0);
        @(negedge clk);
        reset_b = 1'b1;
        idle(1);
        check("rel_h_ready", 32'(bus.h_ready), 1);
        idle(1);

        // imem load at base 5, four words A..D on consecutive cycles
        log_q.delete();
        for (int i = 0; i < 4; i++) payv[i] = 32'hA + 32'(i);
        load(1'b0, 5, 4, -1, 0, 1'b0);
        check("s1_nwr", 32'(log_q.size()), 4);
        if (log_q.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("s1_tgt", 32'(log_q[i].d), 0);
                check("s1_addr", 32'(log_q[i].addr), 32'(5 + i));
                check("s1_data", log_q[i].data, 32'hA + 32'(i));
                check("s1_cyc", 32'(log_q[i].cyc - log_q[0].cyc), 32'(i));
            end
        check("s1_busy_end", 32'(busy), 0);

        // dmem load wrapping from 0x3FE
        log_q.delete();
        for (int i = 0; i < 3; i++) payv[i] = $urandom;
        load(1'b1, 10'h3FE, 3, -1, 0, 1'b0);
        check("s2_nwr", 32'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            check("s2_a0", 32'(log_q[0].addr), 32'h3FE);
            check("s2_a1", 32'(log_q[1].addr), 32'h3FF);
            check("s2_a2", 32'(log_q[2].addr), 32'h000);
            check("s2_tgt", 32'(log_q[2].d), 1);
        end

        // run / stop with discarded words in between
        log_q.delete();
        put(32'h8000_0000);
        idle(1);
        check("s3_tcs_on", 32'(t_cs), 1);
        put(32'h0030_0005);
        put(32'h1234_5678);
        put(32'h4000_0000);
        put(32'hC000_0000);
        idle(1);
        check("s3_tcs_off", 32'(t_cs), 0);
        check("s3_no_wr", 32'(log_q.size()), 0);
        idle(1);

        // 5-cycle valid gap mid-load
        log_q.delete();
        for (int i = 0; i < 8; i++) payv[i] = $urandom;
        load(1'b0, 10'h07C, 8, 3, 5, 1'b0);
        check("s4_nwr", 32'(log_q.size()), 8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++) begin
                check("s4_addr", 32'(log_q[i].addr), 32'((10'h07C + i) % 128));
                check("s4_data", log_q[i].data, payv[i]);
                if (i > 0)
                    check("s4_cyc", 32'(log_q[i].cyc - log_q[i-1].cyc), (i == 3) ? 6 : 1);
            end

`ifdef LOADER_CHECKSUM_EN
        // bad checksum then refused run
        put(32'h0010_0000);
        put(32'h1);
        put(32'h2);
        put(32'h4);
        idle(1);
        check("s5_err", 32'(err), 1);
        put(32'h8000_0000);
        idle(2);
        check("s5_run_refused", 32'(t_cs), 0);
        do_reset();
        check("s5_err_clr", 32'(err), 0);
`endif

        // asynchronous reset while the third of 8 payload words is written
        put({2'b00, 10'd7, 10'd0, 10'd20});
        put(32'h1111_0000);
        put(32'h2222_0000);
        put(32'h3333_0000);
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        bus.h_valid = 1'b0;
        #1;
        check("s6_imem_we", 32'(imem_we), 0);
        check("s6_imem_addr", 32'(imem_addr), 0);
        check("s6_h_ready", 32'(bus.h_ready), 0);
        check("s6_busy", 32'(busy), 0);
        check("s6_mem_din", mem_din, 0);
        idle(2);
        reset_b = 1'b1;
        idle(1);
        check("s6_ready_back", 32'(bus.h_ready), 1);
        log_q.delete();
        payv[0] = 32'hBEEF_0001;
        payv[1] = 32'hBEEF_0002;
        load(1'b0, 9, 2, -1, 0, 1'b0);
        check("s6_nwr", 32'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check("s6_a0", 32'(log_q[0].addr), 9);
            check("s6_a1", 32'(log_q[1].addr), 10);
        end

        // randomized command stream
        for (int it = 0; it < 60; it++) begin
            int r;
            if (e_err && $urandom_range(0, 1) == 1) do_reset();
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                int n;
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) payv[i] = $urandom;
                load(1'($urandom_range(0, 1)), $urandom_range(0, 1023), n,
                     $urandom_range(0, n), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            end else if (r <= 7) begin
                put(32'h8000_0000);
                if (!e_err)
                    for (int i = 0; i < $urandom_range(0, 4); i++)
                        put({2'($urandom_range(0, 2)), 30'($urandom)});
                put(32'hC000_0000 | 32'($urandom_range(0, 1023)));
                idle(1);
            end else if (r == 8) begin
                put(32'hC000_0000);
                idle(1);
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        idle(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/asip_loader.md
ASIP_LOADER -- requirements
Module: asip_loader

Interface
REQ-001 Parameter MEM_W, default 32, host word and memory data width; SHALL be at least 32.
REQ-002 Parameter IMEMADDRW, default 7, instruction memory address width.
REQ-003 Parameter DMEMADDRW, default 10, data memory address width.
REQ-004 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 reset_b  input  1  reset, asynchronous, active-low.
REQ-006 h_valid  input  1  host word valid.
REQ-007 h_ready  output  1  loader can accept a word; transfer occurs when h_valid and h_ready are both high at a rising clk edge.
REQ-008 h_data  input  MEM_W  host word: header, payload or checksum.
REQ-009 imem_we  output  1  instruction memory write strobe, active-high.
REQ-010 imem_addr  output  IMEMADDRW  instruction memory write address.
REQ-011 dmem_we  output  1  data memory write strobe, active-high.
REQ-012 dmem_addr  output  DMEMADDRW  data memory write address.
REQ-013 mem_din  output  MEM_W  write data, shared by both memories.
REQ-014 t_cs  output  1  core select; high means the processor owns the memories and runs.
REQ-015 busy  output  1  high in LOAD or CHK.
REQ-016 err  output  1  sticky checksum error.

Function
REQ-017 FSM states: IDLE, LOAD, CHK, RUN; registered outputs only.
REQ-018 Header fields: [31:30] opcode (00 load imem, 01 load dmem, 10 run, 11 stop); [29:20] count-1; [9:0] base address.
REQ-019 IDLE: h_ready=1; load header -> latch target, base and count, clear checksum, go to LOAD; run header -> RUN if err=0, else stay in IDLE; stop header ignored.
REQ-020 LOAD: h_ready=1; each accepted word SHALL produce exactly one write strobe one cycle later (latency 1), with address = base + index.
REQ-021 Address SHALL wrap modulo 2^IMEMADDRW or 2^DMEMADDRW, using the low address bits only.
REQ-022 After count words: go to CHK when LOADER_CHECKSUM_EN is defined, otherwise to IDLE.
REQ-023 h_valid low in LOAD stalls the load with no write strobe; there is no timeout.
REQ-024 RUN: t_cs=1, both write strobes held 0, h_ready=1; stop header -> IDLE with t_cs=0 the next cycle; all other words are discarded.
REQ-025 At most one of imem_we and dmem_we SHALL be high in any cycle; both SHALL be 0 whenever t_cs=1.
REQ-026 mem_din holds the last payload word between strobes.

Reset
REQ-027 reset_b low SHALL immediately force IDLE and set h_ready=0, imem_we=0, dmem_we=0, t_cs=0, busy=0, err=0, and clear addresses, mem_din, counters and checksum.
REQ-028 h_ready SHALL become 1 on the first clock edge after reset_b is released.
REQ-029 Reset during LOAD or RUN SHALL abort the operation; memory contents already written are not rolled back.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: a running XOR of the payload words is kept; in CHK one word is accepted; a mismatch sets err, and the FSM returns to IDLE in either case.
REQ-031 Macro absent: no CHK state and no checksum logic; err is tied to 0.

Structure
REQ-032 The opcode encodings, header field bit positions and FSM state encodings SHALL live in the shared define package, alongside MEM_W, IMEMADDRW and DMEMADDRW.
REQ-033 One sub-module, loader_hdr_dec, SHALL perform the combinational header decode (opcode, count, base).
REQ-034 The memory-port mux (loader vs. processor, selected by t_cs) belongs to the top level, not to this block.

Verification
REQ-035 Scenario: header 0x0030_0005 then words A,B,C,D -> imem_we on 4 consecutive cycles at addresses 5,6,7,8, data A..D, then IDLE.
REQ-036 Scenario: dmem load, base 0x3FE, count 3 -> dmem_addr sequence 0x3FE, 0x3FF, 0x000.
REQ-037 Scenario: run header 0x8000_0000 -> t_cs=1 next cycle; stop header 0xC000_0000 -> t_cs=0 next cycle; no write strobes while t_cs=1.
REQ-038 Scenario: h_valid dropped for 5 cycles mid-load -> no strobes during the gap, and the address sequence is unbroken afterwards.
REQ-039 Scenario (LOADER_CHECKSUM_EN): payload 0x1,0x2 with checksum 0x4 -> err=1; a following run header is refused (t_cs stays 0).
REQ-040 Scenario: reset_b pulsed low during the third of 8 payload words -> all outputs 0 asynchronously, IDLE, and a fresh header is accepted afterwards.
